// File: rtl/alu_exec_pkg.sv
// Shared types, constants and the single-cycle evaluation function for alu_exec_unit.
// The optional signed-overflow flag is enabled with ALU_EXEC_OVF_EN.
package alu_exec_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_SRL = 3'b011,
    ALU_OR  = 3'b100,
    ALU_AND = 3'b101,
    ALU_SLT = 3'b110,
    ALU_BNE = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              ovf;
  } alu_res_t;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

  function automatic alu_res_t alu_eval(input alu_op_e op,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    alu_res_t          r;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    sum  = a + b;
    diff = a - b;
    r    = '0;
    case (op)
      ALU_ADD: begin
        r.result = sum;
        r.ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        r.result = diff;
        r.ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_BNE: r.result = diff;
      ALU_OR:  r.result = a | b;
      ALU_AND: r.result = a & b;
      ALU_SLT: r.result = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
      // Shift codes only evaluate here when the distance is zero.
      ALU_SLL, ALU_SRL: r.result = b;
      default: r.result = '0;
    endcase
    r.zero = (op == ALU_BNE) ? (a != b) : (r.result == '0);
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Request/result handshake bundle for alu_exec_unit; overflow exists only with ALU_EXEC_OVF_EN.
interface alu_exec_if;
  import alu_exec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        alu_control;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [SHAMT_W-1:0] shamt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              zero;
`ifdef ALU_EXEC_OVF_EN
  logic              overflow;

  modport master (
    output in_valid, alu_control, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, alu_control, a, b, shamt, out_ready,
    output in_ready, out_valid, result, zero, overflow
  );
`else
  modport master (
    output in_valid, alu_control, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_control, a, b, shamt, out_ready,
    output in_ready, out_valid, result, zero
  );
`endif

endinterface

// File: rtl/alu_shift_iter.sv
// Bit-serial shifter: one bit per clock, left or logical right, with a down-counter.
// last_o flags the cycle whose edge brings the counter to zero.
module alu_shift_iter
  import alu_exec_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               left_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] amt_i,
  output logic [DATA_W-1:0]  next_o,
  output logic               last_o
);

  logic [DATA_W-1:0]  shreg_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               left_q;

  assign next_o = left_q ? (shreg_q << 1) : (shreg_q >> 1);
  assign last_o = (cnt_q == SHAMT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
    end else if (load_i) begin
      shreg_q <= data_i;
      cnt_q   <= amt_i;
      left_q  <= left_i;
    end else if (cnt_q != '0) begin
      shreg_q <= next_o;
      cnt_q   <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU: single-cycle ops plus iterative SLL/SRL, result held until consumed.
// Define ALU_EXEC_OVF_EN to add the registered signed-overflow output.
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
`ifdef ALU_EXEC_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  alu_op_e           op;
  alu_res_t          eval;
  logic              accept;
  logic              shift_load;
  logic              shift_last;
  logic [DATA_W-1:0] shift_next;

  assign op         = alu_op_e'(bus.alu_control);
  assign eval       = alu_eval(op, bus.a, bus.b);
  assign accept     = bus.in_valid && (state_q == S_IDLE);
  assign shift_load = accept && is_shift(op) && (bus.shamt != '0);

  alu_shift_iter u_shift (
    .clk    (clk),
    .reset  (reset),
    .load_i (shift_load),
    .left_i (op == ALU_SLL),
    .data_i (bus.b),
    .amt_i  (bus.shamt),
    .next_o (shift_next),
    .last_o (shift_last)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_EXEC_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (shift_load) begin
          state_d = S_SHIFT;
        end else if (accept) begin
          state_d  = S_DONE;
          result_d = eval.result;
          zero_d   = eval.zero;
`ifdef ALU_EXEC_OVF_EN
          ovf_d    = eval.ovf;
`endif
        end
      end
      S_SHIFT: begin
        if (shift_last) begin
          state_d  = S_DONE;
          result_d = shift_next;
          zero_d   = (shift_next == '0);
`ifdef ALU_EXEC_OVF_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_EXEC_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_EXEC_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
`ifdef ALU_EXEC_OVF_EN
  assign bus.overflow  = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = eval.ovf;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed + scoreboard bench for alu_exec_unit (overflow checks only with ALU_EXEC_OVF_EN).
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_exec_if bus ();

  alu_exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic z, input logic v, input int lat);
    exp_t e;
    e.result = r; e.zero = z; e.ovf = v; e.lat = lat;
    return e;
  endfunction

  // Independent reference: overflow from a 33-bit sign-extended sum.
  function automatic exp_t model(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t        e;
    logic [32:0] s33;
    e = mk(32'd0, 1'b0, 1'b0, 1);
    case (op)
      ALU_ADD: begin s33 = {a[31], a} + {b[31], b}; e.result = s33[31:0]; e.ovf = s33[32] ^ s33[31]; end
      ALU_SUB: begin s33 = {a[31], a} - {b[31], b}; e.result = s33[31:0]; e.ovf = s33[32] ^ s33[31]; end
      ALU_SLL: begin e.result = b << sh; e.lat = (sh == 0) ? 1 : int'(sh) + 1; end
      ALU_SRL: begin e.result = b >> sh; e.lat = (sh == 0) ? 1 : int'(sh) + 1; end
      ALU_OR:  e.result = a | b;
      ALU_AND: e.result = a & b;
      ALU_SLT: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_BNE: e.result = a - b;
      default: e.result = 32'd0;
    endcase
    e.zero = (op == ALU_BNE) ? (a != b) : (e.result == 32'd0);
    return e;
  endfunction

  task automatic drive_req(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.a           = a;
    bus.b           = b;
    bus.shamt       = sh;
  endtask

  task automatic scramble();
    bus.in_valid    = 1'b0;
    bus.alu_control = 3'($urandom);
    bus.a           = $urandom;
    bus.b           = $urandom;
    bus.shamt       = 5'($urandom);
  endtask

  task automatic start_op(input string tag, input alu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input exp_t e);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    sb.push_back(e);
    drive_req(op, a, b, sh);
    tick();
    scramble();
  endtask

  task automatic wait_result(input string tag);
    int   lat = 1;
    exp_t e;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_result"}, bus.result, e.result);
    check({tag, "_zero"}, 32'(bus.zero), 32'(e.zero));
`ifdef ALU_EXEC_OVF_EN
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(e.ovf));
`endif
  endtask

  task automatic release_op(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_back_idle"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input alu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input exp_t e);
    start_op(tag, op, a, b, sh, e);
    wait_result(tag);
    release_op(tag);
  endtask

  initial begin
    alu_op_e rop;
    logic [31:0] ra, rb;
    logic [4:0]  rsh;

    reset         = 1'b1;
    bus.out_ready = 1'b0;
    scramble();
    tick();
    tick();
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef ALU_EXEC_OVF_EN
    check("rst_overflow", 32'(bus.overflow), 32'd0);
`endif
    reset = 1'b0;
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_op("add_ovf",  ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, mk(32'h8000_0000, 1'b0, 1'b1, 1));
    run_op("bne_eq",   ALU_BNE, 32'd5, 32'd5, 5'd0, mk(32'd0, 1'b0, 1'b0, 1));
    run_op("bne_ne",   ALU_BNE, 32'd5, 32'd6, 5'd0, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1));
    run_op("sub_zero", ALU_SUB, 32'd5, 32'd5, 5'd0, mk(32'd0, 1'b1, 1'b0, 1));
    run_op("sll_31",   ALU_SLL, 32'h1234, 32'h0000_0001, 5'd31, mk(32'h8000_0000, 1'b0, 1'b0, 32));
    run_op("srl_4",    ALU_SRL, 32'h1234, 32'h8000_0000, 5'd4, mk(32'h0800_0000, 1'b0, 1'b0, 5));
    run_op("sll_0",    ALU_SLL, 32'h1234, 32'hDEAD_BEEF, 5'd0, mk(32'hDEAD_BEEF, 1'b0, 1'b0, 1));
    run_op("srl_out",  ALU_SRL, 32'h1234, 32'h0000_0001, 5'd1, mk(32'd0, 1'b1, 1'b0, 2));
    run_op("slt_neg",  ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, mk(32'd1, 1'b0, 1'b0, 1));
    run_op("slt_pos",  ALU_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0, mk(32'd0, 1'b1, 1'b0, 1));
    run_op("sub_ovf",  ALU_SUB, 32'h8000_0000, 32'd1, 5'd0, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1));
    run_op("or",       ALU_OR,  32'hF0F0_0000, 32'h0000_0F0F, 5'd0, mk(32'hF0F0_0F0F, 1'b0, 1'b0, 1));
    run_op("and",      ALU_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0, mk(32'd0, 1'b1, 1'b0, 1));
    run_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, mk(32'd0, 1'b1, 1'b0, 1));

    // Result held under back-pressure while a competing request is presented.
    start_op("hold", ALU_ADD, 32'd3, 32'd4, 5'd0, mk(32'd7, 1'b0, 1'b0, 1));
    wait_result("hold");
    drive_req(ALU_SUB, 32'd9, 32'd1, 5'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_result", bus.result, 32'd7);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    scramble();
    check("hold_release_idle", 32'(bus.in_ready), 32'd1);
    check("hold_release_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("hold_no_reaccept", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a long shift discards it.
    drive_req(ALU_SRL, 32'd0, 32'hFFFF_0000, 5'd20);
    tick();
    scramble();
    repeat (7) tick();
    check("mid_shift_busy", 32'(bus.in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    run_op("post_rst_sll", ALU_SLL, 32'd0, 32'd1, 5'd3, mk(32'd8, 1'b0, 1'b0, 4));

    for (int i = 0; i < 8; i++) begin
      rop = alu_op_e'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      rsh = 5'($urandom_range(0, 6));
      run_op("rand", rop, ra, rb, rsh, model(rop, ra, rb, rsh));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
